sub_nibble_serial: RTL and testbench
====================================

SUB_NIBBLE_SERIAL -- requirements
Module: sub_nibble_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal values are multiples of 4, at least 8.
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port start  input  1  request pulse, sampled on rising clk.
REQ-005 The block SHALL have port A  input  WIDTH  minuend, sampled only when start is accepted.
REQ-006 The block SHALL have port B  input  WIDTH  subtrahend, sampled only when start is accepted.
REQ-007 The block SHALL have port Bin  input  1  borrow-in, sampled only when start is accepted.
REQ-008 The block SHALL have port busy  output  1  high while an operation is in progress (RUN state).
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-010 The block SHALL have port Diff  output  WIDTH  registered result A - B - Bin, modulo 2^WIDTH.
REQ-011 The block SHALL have port Bout  output  1  registered borrow-out, 1 when A < B + Bin as unsigned values.
REQ-012 The block SHALL have ports Z and V, each output 1, registered zero and signed-overflow flags, present only under REQ-029.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE, with N = WIDTH/4.
REQ-014 The block SHALL accept start only in IDLE; on the accepting edge it latches A, B and Bin, clears the nibble counter and enters RUN.
REQ-015 The block SHALL ignore start in RUN and in DONE, with no effect on operands, counter or outputs.
REQ-016 In RUN, each rising edge SHALL process exactly one nibble, LSB nibble first: nibble i of Diff = A[i] + ~B[i] + c, where c = ~Bin for i = 0 and the registered carry of nibble i-1 otherwise.
REQ-017 The block SHALL move from RUN to DONE on the edge that processes nibble N-1, loading Bout = ~(final carry) on that same edge.
REQ-018 The block SHALL assert done for exactly one cycle in DONE and return to IDLE on the next edge.
REQ-019 Latency SHALL be fixed: with start accepted at edge t, done is high in the cycle following edge t+N (8 cycles for WIDTH = 32).
REQ-020 The block SHALL assert busy exactly while in RUN (N cycles) and deassert it in DONE and IDLE.
REQ-021 Diff SHALL be undefined while busy, and Diff and Bout SHALL hold stable from done until the next accepted start.
REQ-022 A start in the IDLE cycle that directly follows DONE SHALL be accepted, giving back-to-back throughput of one result per N+2 cycles.

Reset
REQ-023 Asserting rst_n low SHALL force, without waiting for clk, state IDLE, counter 0, busy 0, done 0, Diff 0, Bout 0, and Z and V 0 when present.
REQ-024 Reset asserted during RUN or DONE SHALL abort the operation, produce no done pulse, and discard the latched operands.
REQ-025 After rst_n deasserts, the first rising clk with start high SHALL be accepted normally.

Configuration
REQ-026 The block SHALL use macro SUB_NIBBLE_FLAGS_EN to select the flag feature.
REQ-027 With SUB_NIBBLE_FLAGS_EN defined, Z SHALL be loaded with (Diff == 0) on the RUN-to-DONE edge.
REQ-028 With SUB_NIBBLE_FLAGS_EN defined, V SHALL be loaded on that same edge with (A[msb] != B[msb]) AND (Diff[msb] != A[msb]); Bin is included in Diff, and Z and V hold like Diff.
REQ-029 With SUB_NIBBLE_FLAGS_EN undefined, ports Z and V and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH = 32, flags enabled)
REQ-030 The bench SHALL cover: A=0x00000005, B=0x00000003, Bin=0 -> Diff=0x00000002, Bout=0, Z=0, V=0, with done exactly 8 cycles after the accepting edge and busy high for 8 cycles.
REQ-031 The bench SHALL cover: A=0x00000000, B=0x00000001, Bin=0 -> Diff=0xFFFFFFFF, Bout=1, Z=0, V=0.
REQ-032 The bench SHALL cover: A=0x80000000, B=0x00000001, Bin=0 -> Diff=0x7FFFFFFF, Bout=0, V=1; then A=B=0x12345678, Bin=0 -> Diff=0, Z=1; then the same with Bin=1 -> Diff=0xFFFFFFFF, Bout=1, Z=0.
REQ-033 The bench SHALL cover: start held high for 12 cycles with operands changed every cycle -> only the operands of the first accepting edge are used, a second op is accepted in the IDLE cycle after DONE, and exactly two done pulses occur.
REQ-034 The bench SHALL cover: rst_n pulsed low asynchronously (mid-cycle) on the 4th RUN cycle -> all outputs go to 0 immediately, no done pulse, and a following op A=0x00000010, B=0x00000001 -> Diff=0x0000000F.
REQ-035 The bench SHALL cover: the build with SUB_NIBBLE_FLAGS_EN undefined, rerunning REQ-030 to REQ-032 -> identical Diff, Bout and timing, and no Z or V ports.

Source files
------------

// File: rtl/sub_nibble_serial.sv
// sub_nibble_serial
//   Bit-serial-by-nibble subtractor: computes Diff = A - B - Bin (mod 2^WIDTH)
//   one 4-bit nibble per clock, LSB nibble first, using A + ~B + ~Bin.
//   An operation takes N = WIDTH/4 RUN cycles followed by one DONE cycle.
//
// Parameters
//   WIDTH : operand/result width, multiple of 4, at least 8
//
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : request pulse, accepted only in IDLE
//   A, B  : minuend / subtrahend, latched on the accepting edge
//   Bin   : borrow-in, latched on the accepting edge
//   busy  : high while the nibble loop runs (RUN state)
//   done  : one-cycle pulse when Diff/Bout (and flags) are valid
//   Diff  : registered difference
//   Bout  : registered borrow-out (1 when A < B + Bin, unsigned)
//   Z, V  : registered zero / signed-overflow flags, only present when the
//           macro SUB_NIBBLE_FLAGS_EN is defined
module sub_nibble_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB_NIBBLE_FLAGS_EN
  ,
  output logic             Z,
  output logic             V
`endif
);

  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             bout_q, bout_d;
`ifdef SUB_NIBBLE_FLAGS_EN
  logic             z_q, z_d;
  logic             v_q, v_d;
`endif

  logic [4:0]       nib_sum;
  logic             last_nib;

  // Operands are shifted right one nibble per RUN cycle so the current nibble
  // always sits in bits [3:0]; result nibbles enter Diff from the top, so
  // after N shifts the result is fully aligned. On the final step a_q/b_q
  // hold the original top nibbles, which gives the sign bits for V.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    carry_d  = carry_q;
    bout_d   = bout_q;
`ifdef SUB_NIBBLE_FLAGS_EN
    z_d      = z_q;
    v_d      = v_q;
`endif
    nib_sum  = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0000, carry_q};
    last_nib = (cnt_q == CW'(N - 1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = ~Bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        diff_d  = {nib_sum[3:0], diff_q[WIDTH-1:4]};
        carry_d = nib_sum[4];
        cnt_d   = cnt_q + 1'b1;
        if (last_nib) begin
          cnt_d   = '0;
          state_d = S_DONE;
          bout_d  = ~nib_sum[4];
`ifdef SUB_NIBBLE_FLAGS_EN
          z_d     = (diff_d == '0);
          v_d     = (a_q[3] != b_q[3]) && (nib_sum[3] != a_q[3]);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SUB_NIBBLE_FLAGS_EN
      z_q     <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
`ifdef SUB_NIBBLE_FLAGS_EN
      z_q     <= z_d;
      v_q     <= v_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign Diff = diff_q;
  assign Bout = bout_q;
`ifdef SUB_NIBBLE_FLAGS_EN
  assign Z    = z_q;
  assign V    = v_q;
`endif

endmodule

// File: tb/tb_sub_nibble_serial.sv
// tb_sub_nibble_serial
//   Directed self-checking bench for sub_nibble_serial at WIDTH = 32.
//   Flag checks are compiled in only when SUB_NIBBLE_FLAGS_EN is defined.
module tb_sub_nibble_serial;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        bin_in;
  logic        busy;
  logic        done;
  logic [31:0] diff;
  logic        bout;
`ifdef SUB_NIBBLE_FLAGS_EN
  logic        z;
  logic        v;
`endif

  int total;
  int bad;

  sub_nibble_serial #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .Bin   (bin_in),
    .busy  (busy),
    .done  (done),
    .Diff  (diff),
    .Bout  (bout)
`ifdef SUB_NIBBLE_FLAGS_EN
    ,
    .Z     (z),
    .V     (v)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issues one start, then scrambles the inputs. Returns with the bench at
  // the negedge where done is first seen; lat is the number of clock edges
  // from the accepting edge to the edge that raised done (-1 on timeout).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bn,
                       output int lat, output int busy_n);
    @(negedge clk);
    a_in = a; b_in = b; bin_in = bn; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a_in = 32'hDEAD_BEEF; b_in = 32'h1234_0FED; bin_in = ~bn;
    lat = -1; busy_n = 0;
    for (int k = 1; k <= 20; k++) begin
      if (busy) busy_n++;
      if (done) begin lat = k - 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; bin_in = 1'b0;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    total++; if (diff !== 32'h0) begin bad++; $display("[TB] FAIL reset_diff got=%h exp=00000000", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("[TB] FAIL reset_bout got=%b exp=0", bout); end
`ifdef SUB_NIBBLE_FLAGS_EN
    total++; if (z !== 1'b0) begin bad++; $display("[TB] FAIL reset_z got=%b exp=0", z); end
    total++; if (v !== 1'b0) begin bad++; $display("[TB] FAIL reset_v got=%b exp=0", v); end
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bn;
    do_op(32'h0000_0005, 32'h0000_0003, 1'b0, lat, bn);
    total++; if (lat !== 8) begin bad++; $display("[TB] FAIL basic_latency got=%0d exp=8", lat); end
    total++; if (bn !== 8) begin bad++; $display("[TB] FAIL basic_busy_cycles got=%0d exp=8", bn); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_in_done got=%b exp=0", busy); end
    total++; if (diff !== 32'h0000_0002) begin bad++; $display("[TB] FAIL basic_diff got=%h exp=00000002", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("[TB] FAIL basic_bout got=%b exp=0", bout); end
`ifdef SUB_NIBBLE_FLAGS_EN
    total++; if (z !== 1'b0) begin bad++; $display("[TB] FAIL basic_z got=%b exp=0", z); end
    total++; if (v !== 1'b0) begin bad++; $display("[TB] FAIL basic_v got=%b exp=0", v); end
`endif
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL basic_done_width got=%b exp=0", done); end
    @(negedge clk);
    total++; if (diff !== 32'h0000_0002) begin bad++; $display("[TB] FAIL basic_diff_hold got=%h exp=00000002", diff); end
  endtask

  task automatic test_borrow();
    int lat, bn;
    do_op(32'h0000_0000, 32'h0000_0001, 1'b0, lat, bn);
    total++; if (lat !== 8) begin bad++; $display("[TB] FAIL borrow_latency got=%0d exp=8", lat); end
    total++; if (diff !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL borrow_diff got=%h exp=ffffffff", diff); end
    total++; if (bout !== 1'b1) begin bad++; $display("[TB] FAIL borrow_bout got=%b exp=1", bout); end
`ifdef SUB_NIBBLE_FLAGS_EN
    total++; if (z !== 1'b0) begin bad++; $display("[TB] FAIL borrow_z got=%b exp=0", z); end
    total++; if (v !== 1'b0) begin bad++; $display("[TB] FAIL borrow_v got=%b exp=0", v); end
`endif
  endtask

  task automatic test_flags_edges();
    int lat, bn;
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0, lat, bn);
    total++; if (lat !== 8) begin bad++; $display("[TB] FAIL ovf_latency got=%0d exp=8", lat); end
    total++; if (diff !== 32'h7FFF_FFFF) begin bad++; $display("[TB] FAIL ovf_diff got=%h exp=7fffffff", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("[TB] FAIL ovf_bout got=%b exp=0", bout); end
`ifdef SUB_NIBBLE_FLAGS_EN
    total++; if (v !== 1'b1) begin bad++; $display("[TB] FAIL ovf_v got=%b exp=1", v); end
    total++; if (z !== 1'b0) begin bad++; $display("[TB] FAIL ovf_z got=%b exp=0", z); end
`endif
    do_op(32'h1234_5678, 32'h1234_5678, 1'b0, lat, bn);
    total++; if (diff !== 32'h0000_0000) begin bad++; $display("[TB] FAIL zero_diff got=%h exp=00000000", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("[TB] FAIL zero_bout got=%b exp=0", bout); end
`ifdef SUB_NIBBLE_FLAGS_EN
    total++; if (z !== 1'b1) begin bad++; $display("[TB] FAIL zero_z got=%b exp=1", z); end
    total++; if (v !== 1'b0) begin bad++; $display("[TB] FAIL zero_v got=%b exp=0", v); end
`endif
    do_op(32'h1234_5678, 32'h1234_5678, 1'b1, lat, bn);
    total++; if (lat !== 8) begin bad++; $display("[TB] FAIL bin_latency got=%0d exp=8", lat); end
    total++; if (diff !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL bin_diff got=%h exp=ffffffff", diff); end
    total++; if (bout !== 1'b1) begin bad++; $display("[TB] FAIL bin_bout got=%b exp=1", bout); end
`ifdef SUB_NIBBLE_FLAGS_EN
    total++; if (z !== 1'b0) begin bad++; $display("[TB] FAIL bin_z got=%b exp=0", z); end
`endif
  endtask

  // start held high for 12 edges with operands j-dependent:
  // A_j = 0x11111111*(j+1), B_j = j+1. Accepts happen at edge 0 and edge 10
  // (the IDLE cycle after the first DONE), so the results are
  // 0x11111111-1 = 0x11111110 and 0xBBBBBBBB-0xB = 0xBBBBBBB0.
  task automatic test_back_to_back();
    int done_n;
    int first_at, second_at;
    logic [31:0] first_diff, second_diff;
    done_n = 0; first_at = -1; second_at = -1;
    first_diff = '0; second_diff = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        done_n++;
        if (done_n == 1) begin first_at = i; first_diff = diff; end
        if (done_n == 2) begin second_at = i; second_diff = diff; end
      end
      if (i < 12) begin
        a_in = 32'h1111_1111 * (i + 1); b_in = 32'(i + 1); bin_in = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    total++; if (done_n !== 2) begin bad++; $display("[TB] FAIL b2b_done_count got=%0d exp=2", done_n); end
    total++; if (first_at !== 9) begin bad++; $display("[TB] FAIL b2b_first_done_cycle got=%0d exp=9", first_at); end
    total++; if (second_at !== 19) begin bad++; $display("[TB] FAIL b2b_second_done_cycle got=%0d exp=19", second_at); end
    total++; if (first_diff !== 32'h1111_1110) begin bad++; $display("[TB] FAIL b2b_first_diff got=%h exp=11111110", first_diff); end
    total++; if (second_diff !== 32'hBBBB_BBB0) begin bad++; $display("[TB] FAIL b2b_second_diff got=%h exp=bbbbbbb0", second_diff); end
  endtask

  task automatic test_reset_mid_run();
    int lat, bn, done_n;
    @(negedge clk);
    a_in = 32'hFFFF_FFFF; b_in = 32'h0000_0000; bin_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_done got=%b exp=0", done); end
    total++; if (diff !== 32'h0) begin bad++; $display("[TB] FAIL midrst_diff got=%h exp=00000000", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("[TB] FAIL midrst_bout got=%b exp=0", bout); end
`ifdef SUB_NIBBLE_FLAGS_EN
    total++; if (z !== 1'b0 || v !== 1'b0) begin bad++; $display("[TB] FAIL midrst_flags got=%b%b exp=00", z, v); end
`endif
    #1 rst_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    total++; if (done_n !== 0) begin bad++; $display("[TB] FAIL midrst_no_done got=%0d exp=0", done_n); end
    do_op(32'h0000_0010, 32'h0000_0001, 1'b0, lat, bn);
    total++; if (lat !== 8) begin bad++; $display("[TB] FAIL postrst_latency got=%0d exp=8", lat); end
    total++; if (diff !== 32'h0000_000F) begin bad++; $display("[TB] FAIL postrst_diff got=%h exp=0000000f", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("[TB] FAIL postrst_bout got=%b exp=0", bout); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_flags_edges();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
